// File: rtl/pendigits_feature_loader.sv
// pendigits_feature_loader: packs a serial stream of B-bit features into an N*B frame bus, waits SETTLE cycles, registers the classifier klass and hands it downstream
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid/s_data/s_last/s_ready   feature stream in (valid/ready)
//   inp                        registered frame bus driving the classifier
//   klass_in                   classifier result (combinational function of inp)
//   m_valid/m_klass/m_ready    registered class result out (valid/ready)
//   frame_err                  one-cycle pulse on a framing error
// Build option: define PENDIGITS_LOADER_FRAME_CHK_EN to check s_last against the
// beat count and discard mis-framed frames; otherwise frames close on count alone.
module pendigits_feature_loader #(
  parameter int N = 16,
  parameter int B = 4,
  parameter int C = 10,
  parameter int SETTLE = 1,
  localparam int KW = $clog2(C)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  input  logic [B-1:0]   s_data,
  input  logic           s_last,
  output logic           s_ready,
  output logic [N*B-1:0] inp,
  input  logic [KW-1:0]  klass_in,
  output logic           m_valid,
  output logic [KW-1:0]  m_klass,
  input  logic           m_ready,
  output logic           frame_err
);
  localparam int CW = $clog2(N);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [N*B-1:0] inp_q, inp_d;
  logic m_valid_q, m_valid_d;
  logic [KW-1:0] m_klass_q, m_klass_d;
  logic acc, last, err;
  assign s_ready = (state_q == ST_LOAD);
  assign acc = s_valid && s_ready;
  assign last = (cnt_q == CW'(N - 1));
  assign inp = inp_q;
  assign m_valid = m_valid_q;
  assign m_klass = m_klass_q;
`ifdef PENDIGITS_LOADER_FRAME_CHK_EN
  logic frame_err_q;
  assign err = acc && (s_last != last);
  assign frame_err = frame_err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_err_q <= 1'b0;
    else frame_err_q <= err;
`else
  logic unused_last;
  assign unused_last = s_last;
  assign err = 1'b0;
  assign frame_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    scnt_d = scnt_q;
    inp_d = inp_q;
    m_valid_d = m_valid_q;
    m_klass_d = m_klass_q;
    case (state_q)
      ST_LOAD: if (acc) begin
        // k-th beat of a frame lands at nibble N-1-k, so the first feature is the MS nibble
        inp_d[(N - 1 - int'(cnt_q)) * B +: B] = s_data;
        cnt_d = (err || last) ? '0 : cnt_q + 1'b1;
        if (last && !err) begin
          state_d = ST_SETTLE;
          scnt_d = '0;
        end
      end
      ST_SETTLE: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == SW'(SETTLE - 1)) begin
          m_klass_d = klass_in;
          m_valid_d = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: if (m_ready) begin
        m_valid_d = 1'b0;
        cnt_d = '0;
        state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q <= '0;
      scnt_q <= '0;
      inp_q <= '0;
      m_valid_q <= 1'b0;
      m_klass_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      scnt_q <= scnt_d;
      inp_q <= inp_d;
      m_valid_q <= m_valid_d;
      m_klass_q <= m_klass_d;
    end
endmodule
